// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher core scheduler.
// Holds data/key widths, the post-reset key, the default RUN timeout and
// the scheduler state encoding, plus the round-robin pick helper.
package cipher_pkg;

    localparam int unsigned DATA_W          = 64;
    localparam int unsigned KEY_W           = 80;
    localparam int unsigned TIMEOUT_CYC_DEF = 20000;

    localparam logic [KEY_W-1:0] DEFAULT_KEY = 80'hffff_ffff_ffff_ffff_ffff;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StResp
    } sched_state_e;

    // Returns the index of the requester to grant. On a tie the requester
    // that was not served last wins; a single valid requester always wins.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
        logic pick;
        if (valid == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = valid[1];
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for a level crossing into clk_i, with a rising-edge
// detect taken from an extra edge register behind the synchronizer.
// Ports:
//   clk_i    destination clock
//   rst_i    asynchronous active-high reset, clears all flops
//   d_i      asynchronous level input
//   level_o  synchronized level
//   rise_o   one-cycle pulse on a synchronized 0->1 transition
module sync_rise (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Built only from flops past the metastable stage, so it is glitch-free.
    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/cipher_sched.sv
// Round-robin sequencer sharing one block-cipher core between two requesters.
// Accepts a plaintext from the granted requester, holds the core's level
// start handshake until the (asynchronous) end level rises or a timeout
// expires, waits for end to fall again, then returns the result or a timeout
// error to the owning requester.
// Ports:
//   sys_clk_i, sys_rst_i     clock, asynchronous active-high reset
//   req_valid_i/req_data*_i  requests; req_ready_o one-hot accept strobe
//   rsp_valid_o/rsp_data_o   one-hot response to the owner, rsp_err_o = timeout
//   rsp_ready_i              per-requester response accept
//   key_wr_i/key_data_i      key shadow update, applied at the next launch
//   core_start_o/state/keys  core launch handshake and operands
//   core_end_i/core_result_i core completion level and result
//   busy_o                   high whenever not idle
module cipher_sched
    import cipher_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [1:0]        req_valid_i,
    input  logic [DATA_W-1:0] req_data0_i,
    input  logic [DATA_W-1:0] req_data1_i,
    output logic [1:0]        req_ready_o,
    output logic [1:0]        rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    input  logic [1:0]        rsp_ready_i,
    input  logic              key_wr_i,
    input  logic [KEY_W-1:0]  key_data_i,
    output logic              core_start_o,
    output logic [DATA_W-1:0] core_state_o,
    output logic [KEY_W-1:0]  core_keys_o,
    input  logic              core_end_i,
    input  logic [DATA_W-1:0] core_result_i,
    output logic              busy_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    sched_state_e      state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [CntW-1:0]   cnt_q;
    logic              core_start_q;
    logic [DATA_W-1:0] core_state_q;
    logic [KEY_W-1:0]  core_keys_q;
    logic [KEY_W-1:0]  key_shadow_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic end_level;
    logic end_rise;
    logic any_req;
    logic grant;
    logic owner_ready;

    sync_rise u_end_sync (
        .clk_i   (sys_clk_i),
        .rst_i   (sys_rst_i),
        .d_i     (core_end_i),
        .level_o (end_level),
        .rise_o  (end_rise)
    );

    assign any_req     = |req_valid_i;
    assign grant       = rr_pick(req_valid_i, last_grant_q);
    assign owner_ready = owner_q ? rsp_ready_i[1] : rsp_ready_i[0];

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            core_state_q <= '0;
            core_keys_q  <= DEFAULT_KEY;
            key_shadow_q <= DEFAULT_KEY;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // The launch below samples the old shadow, so a key written in
            // the accept cycle only applies from the next request on.
            if (key_wr_i) begin
                key_shadow_q <= key_data_i;
            end

            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        core_state_q <= grant ? req_data1_i : req_data0_i;
                        core_keys_q  <= key_shadow_q;
                        owner_q      <= grant;
                        core_start_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= StRun;
                    end
                end
                StRun: begin
                    // Rise is tested first so it wins over a same-cycle timeout.
                    if (end_rise) begin
                        rsp_data_q   <= core_result_i;
                        rsp_err_q    <= 1'b0;
                        core_start_q <= 1'b0;
                        state_q      <= StDrain;
                    end else if (cnt_q == CntLast) begin
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b1;
                        core_start_q <= 1'b0;
                        state_q      <= StDrain;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    // The core must drop end before it can see a fresh start.
                    if (!end_level) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (owner_ready) begin
                        last_grant_q <= owner_q;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == StIdle && any_req) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid_o  = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;
    assign core_start_o = core_start_q;
    assign core_state_o = core_state_q;
    assign core_keys_o  = core_keys_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/cipher_sched.md
# cipher_sched

Sequencer and round-robin arbiter sharing one IVLBC 64-bit block-cipher core between two requesters (req 0: UART loopback path, req 1: local/self-test source). Accepts a 64-bit plaintext from the granted requester, drives the core's level-held start/end handshake across the core's slower clock, applies the current 80-bit key, and returns the result (or a timeout error) to the owning requester. It replaces ad-hoc start/end handling in the loopback top level.

## Interface
- DATA_W, 64, plaintext/ciphertext width
- KEY_W, 80, key width
- TIMEOUT_CYC, 20000, sys_clk cycles allowed in RUN before abort
- DEFAULT_KEY, 80'hffff_ffff_ffff_ffff_ffff, key after reset
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_data0 / req_data1  in  DATA_W  plaintext of requester 0 / 1
- req_ready  out  2  one-hot accept strobe, one cycle
- rsp_valid  out  2  one-hot response valid to owning requester
- rsp_data  out  DATA_W  result; 0 on error
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout
- rsp_ready  in  2  per-requester response accept
- key_wr  in  1  key update strobe
- key_data  in  KEY_W  new key
- core_start  out  1  held high from launch until end seen or timeout
- core_state  out  DATA_W  plaintext to core, stable while core_start high
- core_keys  out  KEY_W  key to core, stable while core_start high
- core_end  in  1  core done level, asynchronous to sys_clk
- core_result  in  DATA_W  core output, valid while core_end high
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, RUN, DRAIN, RESP.
- IDLE: if any req_valid, grant per round-robin; assert req_ready[g] combinationally that cycle; register core_state, core_keys <= key_shadow, owner <= g, core_start <= 1; go RUN.
- Round-robin: last_grant resets to 1 (requester 0 wins first tie); on tie grant ~last_grant; single valid always granted.
- RUN: core_end passes a 2-flop synchronizer plus rise detector. On rise: rsp_data <= core_result, rsp_err <= 0, core_start <= 0, go DRAIN. Timeout counter reaching TIMEOUT_CYC-1 without rise: rsp_data <= 0, rsp_err <= 1, core_start <= 0, go DRAIN. Rise and timeout same cycle: rise wins.
- DRAIN: wait synchronized core_end == 0, then go RESP (guarantees core re-armed before next start).
- RESP: rsp_valid[owner] = 1 holding rsp_data/rsp_err until rsp_ready[owner]; then last_grant <= owner, go IDLE. rsp_ready of non-owner ignored.
- Key: key_wr loads key_shadow any state; in-flight operation keeps its latched core_keys. key_wr in the accept cycle: launch uses old shadow; new key from next request.
- Reset (anytime, incl. mid-RUN): state IDLE, core_start 0, core_state 0, core_keys DEFAULT_KEY, key_shadow DEFAULT_KEY, rsp_valid 0, rsp_data 0, rsp_err 0, req_ready 0, busy 0, last_grant 1, counter 0, sync flops 0.

## Timing
- Request accept to core_start high: 1 cycle.
- core_end rising at pin to capture: 3 sys_clk cycles (2 sync + edge register).
- DRAIN exit: 2–3 cycles after core_end falls.
- RESP to IDLE: same cycle as rsp_ready[owner]; next accept earliest following cycle.
- Minimum back-to-back request spacing: accept, RUN ≥3, DRAIN ≥1, RESP ≥1 cycles.
- Timeout counter: width $clog2(TIMEOUT_CYC), cleared on every launch, no wrap in RUN.

## Structure
- Shared package cipher_pkg: state encoding, DATA_W/KEY_W, DEFAULT_KEY, TIMEOUT_CYC default.
- Sub-module sync_rise: 2-flop synchronizer with registered rising-edge output and synced level; reused for core_end.

## Test plan
- Single request: req_valid=01, req_data0=64'h0123_4567_89ab_cdef, model core returns 64'hdead_beef_0000_0001 -> rsp_valid=01, rsp_data matches, rsp_err=0, core_keys=DEFAULT_KEY.
- Tie: req_valid=11 held -> grants 0,1,0,1; each rsp_valid routed to the granted requester only.
- Timeout: core_end never rises, TIMEOUT_CYC=50 -> core_start drops after 50 RUN cycles, rsp_err=1, rsp_data=0.
- Key change: key_wr with 80'h0 during RUN -> current op uses DEFAULT_KEY, next op core_keys=80'h0.
- Stuck end: core_end stays high after result -> stays in DRAIN, no rsp_valid until it falls, then response.
- Reset mid-RUN: sys_rst pulse -> core_start 0, busy 0, all outputs at reset values; next request starts cleanly.
